// File: rtl/soc_system_pio_status_in.sv
// soc_system_pio_status_in
// Avalon-MM input PIO slave. It makes coprocessor status lines readable by the HPS.
// The in_port lines are synchronized into clk.
// Selected edges on each bit are latched into a write-1-to-clear capture register.
// A level irq is raised while any captured bit is also set in irq_mask.
// Register map (word addresses):
//   0 DATA      synchronized in_port (read-only)
//   1 reserved  reads 0, writes ignored
//   2 IRQ_MASK  read/write
//   3 EDGE_CAP  sticky edge capture, write 1 to clear
// Reads are combinational (latency 0) and have no side effects. There is no waitrequest.

module soc_system_pio_status_in #(
  parameter int WIDTH       = 32,  // 1..32
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int EDGE_TYPE   = 0    // 0 rising, 1 falling, 2 any
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } reg_addr_e;

  // Warm-up spans the synchronizer depth plus the previous-sample stage.
  // Until that time has passed, the edge detector compares against reset zeros.
  localparam int         WARM_LEN  = SYNC_STAGES + 1;
  localparam logic [2:0] WARM_LAST = 3'(WARM_LEN);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [2:0]       warm_cnt;
  logic             warm_done;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clear;
  logic             wr_en;
  logic             mask_we;
  logic             cap_we;

  // ---------------------------------------------------------------------------
  // Input synchronizer and previous-sample register
  // ---------------------------------------------------------------------------
  // Shift in_port through SYNC_STAGES flops. The last stage is the clean sample.
  // NOTE: every flop in the chain is reset, not only the last stage. This gives
  // DATA a defined 0 immediately after reset and the warm-up a known start point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's
      // old value, which forms a shift register. With blocking assignments,
      // in_port would ripple through every stage in a single edge.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Delay the synchronized value by one more clk to detect edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up counter
  // ---------------------------------------------------------------------------
  // Count clks after reset release and saturate at WARM_LEN. Until then, edges
  // seen against the all-zero reset state are ignored. This stops a line held
  // high through reset from appearing as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign warm_done = (warm_cnt == WARM_LAST);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  // Select the edge polarity for this instance and gate it with warm-up.
  always_comb begin
    // NOTE: assigning a default first guarantees edge_sel is driven on every
    // path through the case. This keeps the block purely combinational, so
    // no latch is inferred.
    edge_sel = '0;
    rise     = sync & ~prev;
    fall     = ~sync & prev;
    case (EDGE_TYPE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
    edge_hit = warm_done ? edge_sel : '0;
  end

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  // Qualify the write strobe and decode which register it targets.
  always_comb begin
    wr_en     = chipselect && !write_n;
    mask_we   = wr_en && (reg_addr_e'(address) == ADDR_IRQ_MASK);
    cap_we    = wr_en && (reg_addr_e'(address) == ADDR_EDGE_CAP);
    wdata     = writedata[WIDTH-1:0];
    cap_clear = cap_we ? wdata : '0;
  end

  // ---------------------------------------------------------------------------
  // IRQ_MASK register
  // ---------------------------------------------------------------------------
  // Plain read/write register. The new value applies from the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (mask_we) begin
      irq_mask <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // EDGE_CAP register
  // ---------------------------------------------------------------------------
  // Apply the clear first, then OR in new edges. A bit that is cleared and hit
  // by an edge in the same clk therefore stays set, so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clear) | edge_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Zero-latency read path. Bits above WIDTH and the reserved word read 0.
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:     readdata[WIDTH-1:0] = sync;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
      default:       readdata = '0;
    endcase
  end

  // irq depends only on registers. in_port and the bus have no combinational
  // path to it.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_status_in.sv
// Directed testbench for soc_system_pio_status_in.
// Three instances share one bus and one in_port, one for each EDGE_TYPE.
// Each step checks only the instance whose behaviour it targets.

module tb_soc_system_pio_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int compared;
  int mismatched;

  soc_system_pio_status_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  soc_system_pio_status_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  soc_system_pio_status_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  // Clock with a period of 20 time units. Each half-cycle leaves room for
  // several #1-spaced reads.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] rd_of(input int idx);
    case (idx)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic irq_of(input int idx);
    case (idx)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Wait for n falling edges. All drives and checks happen just after a
  // falling edge, well away from the rising edge.
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_chk(input int idx, input logic [1:0] addr, input logic [31:0] exp, input string tag);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = addr;
    #1;
    check(tag, rd_of(idx), exp);
  endtask

  task automatic irq_chk(input int idx, input logic exp, input string tag);
    #1;
    check(tag, {31'd0, irq_of(idx)}, {31'd0, exp});
  endtask

  // Issue one write. It lands on the next rising edge, and the task returns
  // at the falling edge after it.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 32'hFFFF_FFFF;

    // ---- Reset state ----
    #2;
    irq_chk(0, 1'b0, "reset_irq");
    read_chk(0, 2'd0, 32'h0, "reset_data");
    read_chk(0, 2'd1, 32'h0, "reset_addr1");
    read_chk(0, 2'd2, 32'h0, "reset_mask");
    read_chk(0, 2'd3, 32'h0, "reset_cap");

    // ---- Test 1: in_port held high through reset ----
    wait_neg(1);
    reset_n = 1'b1;
    wait_neg(10);
    read_chk(0, 2'd3, 32'h0, "t1_cap_rise");
    read_chk(2, 2'd3, 32'h0, "t1_cap_any");
    irq_chk(0, 1'b0, "t1_irq");
    read_chk(0, 2'd0, 32'hFFFF_FFFF, "t1_data");
    wait_neg(1);
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h1234_5678);
    read_chk(0, 2'd0, 32'hFFFF_FFFF, "t1_data_wr_ignored");
    read_chk(0, 2'd1, 32'h0, "t1_addr1_wr_ignored");

    // ---- Test 2: rising edge on bit 0, mask bit 0, W1C ----
    in_port = 32'h0;
    wait_neg(4);
    read_chk(0, 2'd3, 32'h0, "t2_no_fall_capture");
    bus_write(2'd2, 32'h1);
    read_chk(0, 2'd2, 32'h1, "t2_mask_readback");
    in_port = 32'h1;                      // meets setup before edge k
    wait_neg(1);                          // after edge k
    read_chk(0, 2'd0, 32'h0, "t2_data_k");
    wait_neg(1);                          // after edge k+1
    read_chk(0, 2'd0, 32'h1, "t2_data_k1");
    read_chk(0, 2'd3, 32'h0, "t2_cap_k1");
    irq_chk(0, 1'b0, "t2_irq_k1");
    wait_neg(1);                          // after edge k+2
    read_chk(0, 2'd3, 32'h1, "t2_cap_k2");
    irq_chk(0, 1'b1, "t2_irq_k2");
    bus_write(2'd3, 32'h1);
    read_chk(0, 2'd3, 32'h0, "t2_cap_cleared");
    irq_chk(0, 1'b0, "t2_irq_cleared");

    // ---- Test 3: masked-out capture, then unmask ----
    bus_write(2'd2, 32'h0);
    in_port = 32'h21;
    wait_neg(4);
    in_port = 32'h01;
    wait_neg(5);
    read_chk(0, 2'd3, 32'h20, "t3_cap");
    irq_chk(0, 1'b0, "t3_irq_masked");
    bus_write(2'd2, 32'h20);
    irq_chk(0, 1'b1, "t3_irq_unmasked");
    bus_write(2'd3, 32'h20);
    irq_chk(0, 1'b0, "t3_irq_cleared");

    // ---- Test 4: clear and new edge on bit 3 in the same clk ----
    in_port = 32'h05;                     // rise on bit 2
    wait_neg(3);
    read_chk(0, 2'd3, 32'h04, "t4_cap_bit2");
    in_port = 32'h0D;                     // rise on bit 3, captured at edge k+2
    wait_neg(2);                          // now after edge k+1
    bus_write(2'd3, 32'h0C);              // clear lands on edge k+2
    read_chk(0, 2'd3, 32'h08, "t4_edge_wins");
    wait_neg(2);
    read_chk(0, 2'd3, 32'h08, "t4_bit3_sticky");

    // ---- Test 5: falling/any-edge instances on bit 7 ----
    reset_n = 1'b0;
    in_port = 32'h80;
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(6);
    read_chk(2, 2'd3, 32'h0, "t5_any_warmup");
    read_chk(1, 2'd3, 32'h0, "t5_fall_warmup");
    in_port = 32'h00;                     // 1->0 on bit 7
    wait_neg(3);
    read_chk(2, 2'd3, 32'h80, "t5_any_fall");
    read_chk(1, 2'd3, 32'h80, "t5_fall_fall");
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_chk(2, 2'd3, 32'h0, "t5_any_cleared");
    read_chk(1, 2'd3, 32'h0, "t5_fall_cleared");
    in_port = 32'h80;                     // 0->1 on bit 7
    wait_neg(3);
    read_chk(2, 2'd3, 32'h80, "t5_any_rise");
    read_chk(1, 2'd3, 32'h0, "t5_fall_ignores_rise");

    // ---- Test 6: reset pulse mid-operation ----
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h8001);
    in_port = 32'h8081;                   // rises on bits 0 and 15
    wait_neg(3);
    read_chk(0, 2'd3, 32'h8001, "t6_cap_before");
    irq_chk(0, 1'b1, "t6_irq_before");
    wait_neg(1);
    reset_n = 1'b0;
    irq_chk(0, 1'b0, "t6_irq_async_drop");
    wait_neg(1);
    reset_n = 1'b1;
    read_chk(0, 2'd0, 32'h0, "t6_data_after");
    read_chk(0, 2'd1, 32'h0, "t6_addr1_after");
    read_chk(0, 2'd2, 32'h0, "t6_mask_after");
    read_chk(0, 2'd3, 32'h0, "t6_cap_after");
    wait_neg(10);
    read_chk(0, 2'd3, 32'h0, "t6_cap_warmup");
    read_chk(0, 2'd0, 32'h8081, "t6_data_resync");
    irq_chk(0, 1'b0, "t6_irq_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
